sram_dp_fwd_bit_en: RTL and testbench

Single-clock, parametrised true-dual-port SRAM model with per-bit write enables. Supports a selectable read latency and resolves same-cycle port conflicts deterministically: port-A priority on write-write overlap, and write-to-read forwarding. Adds output-valid strobes, sticky error flags and a saturating collision counter. It replaces ad-hoc dual-port buffers in line buffers and cost-aggregation stages, where both ports run on the pixel clock.

---
 rtl/sram_dp_fwd_bit_en_if.sv | 46 ++++
 rtl/sram_dp_fwd_bit_en.sv | 128 ++++++++++++
 tb/tb_sram_dp_fwd_bit_en.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_dp_fwd_bit_en_if.sv
// Bus bundle for the dual-port bit-enable SRAM: both port command/data groups,
// the read-data strobes and the error/collision status.
interface sram_dp_fwd_bit_en_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] din_a;
  logic                  ce_a;
  logic                  wr_en_a;
  logic [DATA_WIDTH-1:0] bit_en_a;
  logic [DATA_WIDTH-1:0] dout_a;
  logic                  dout_vld_a;

  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] din_b;
  logic                  ce_b;
  logic                  wr_en_b;
  logic [DATA_WIDTH-1:0] bit_en_b;
  logic [DATA_WIDTH-1:0] dout_b;
  logic                  dout_vld_b;

  logic                  err_clr;
  logic                  ww_err;
  logic                  oob_err;
  logic [CNT_WIDTH-1:0]  coll_cnt;

  // No back-pressure: a command is taken every cycle its ce is low, and
  // dout_vld is a one-cycle strobe that the consumer must capture when seen.
  modport master (
    output addr_a, din_a, ce_a, wr_en_a, bit_en_a,
    output addr_b, din_b, ce_b, wr_en_b, bit_en_b,
    output err_clr,
    input  dout_a, dout_vld_a, dout_b, dout_vld_b,
    input  ww_err, oob_err, coll_cnt
  );

  modport slave (
    input  addr_a, din_a, ce_a, wr_en_a, bit_en_a,
    input  addr_b, din_b, ce_b, wr_en_b, bit_en_b,
    input  err_clr,
    output dout_a, dout_vld_a, dout_b, dout_vld_b,
    output ww_err, oob_err, coll_cnt
  );
endinterface

// File: rtl/sram_dp_fwd_bit_en.sv
// True dual-port SRAM with active-low per-bit write enables, A-priority on
// write-write overlap, write-to-read forwarding, 1 or 2 cycle read latency.
module sram_dp_fwd_bit_en #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SPACE = 1024,
  parameter int READ_LAT   = 1,
  parameter int CNT_WIDTH  = 16
) (
  input logic              clk,
  input logic              rst_n,
  sram_dp_fwd_bit_en_if.slave bus
);
  localparam int IW = (ADDR_SPACE > 1) ? $clog2(ADDR_SPACE) : 1;
  localparam logic [ADDR_WIDTH:0] SPACE = (ADDR_WIDTH+1)'(ADDR_SPACE);

  logic [DATA_WIDTH-1:0] mem [ADDR_SPACE];

  logic                  in_a, in_b;
  logic                  rd_a, rd_b;
  logic                  wr_a, wr_b;
  logic                  same, coll, ww_hit, oob_ev;
  logic [IW-1:0]         ia, ib;
  logic [DATA_WIDTH-1:0] en_a, en_b;
  logic [DATA_WIDTH-1:0] old_a, old_b;
  logic [DATA_WIDTH-1:0] wdat_a, wdat_b, merged;
  logic [DATA_WIDTH-1:0] rdat_a, rdat_b;

  assign in_a = {1'b0, bus.addr_a} < SPACE;
  assign in_b = {1'b0, bus.addr_b} < SPACE;
  assign ia   = bus.addr_a[IW-1:0];
  assign ib   = bus.addr_b[IW-1:0];

  assign rd_a = !bus.ce_a && bus.wr_en_a;
  assign rd_b = !bus.ce_b && bus.wr_en_b;
  // wr_* only covers in-range writes; out-of-range writes touch nothing.
  assign wr_a = !bus.ce_a && !bus.wr_en_a && in_a;
  assign wr_b = !bus.ce_b && !bus.wr_en_b && in_b;
  assign en_a = wr_a ? ~bus.bit_en_a : '0;
  assign en_b = wr_b ? ~bus.bit_en_b : '0;

  assign same   = !bus.ce_a && !bus.ce_b && in_a && in_b && (bus.addr_a == bus.addr_b);
  assign coll   = same && (!bus.wr_en_a || !bus.wr_en_b);
  assign ww_hit = same && wr_a && wr_b && (|(en_a & en_b));
  assign oob_ev = (!bus.ce_a && !in_a) || (!bus.ce_b && !in_b);

  assign old_a  = mem[ia];
  assign old_b  = mem[ib];
  assign wdat_a = (old_a & ~en_a) | (bus.din_a & en_a);
  assign wdat_b = (old_b & ~en_b) | (bus.din_b & en_b);
  // Bits enabled on both ports resolve to A.
  assign merged = (old_a & ~(en_a | en_b)) | (bus.din_a & en_a) | (bus.din_b & en_b & ~en_a);

  // A reader sees the other port's new bits when it writes the same word.
  assign rdat_a = !in_a ? '0 : (same && wr_b) ? wdat_b : old_a;
  assign rdat_b = !in_b ? '0 : (same && wr_a) ? wdat_a : old_b;

  // Array is deliberately outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_a && wr_b && same) begin
      mem[ia] <= merged;
    end else begin
      if (wr_a) mem[ia] <= wdat_a;
      if (wr_b) mem[ib] <= wdat_b;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] p_a, p_b;
      logic                  pv_a, pv_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p_a            <= '0;
          p_b            <= '0;
          pv_a           <= 1'b0;
          pv_b           <= 1'b0;
          bus.dout_a     <= '0;
          bus.dout_b     <= '0;
          bus.dout_vld_a <= 1'b0;
          bus.dout_vld_b <= 1'b0;
        end else begin
          pv_a           <= rd_a;
          pv_b           <= rd_b;
          bus.dout_vld_a <= pv_a;
          bus.dout_vld_b <= pv_b;
          if (rd_a) p_a <= rdat_a;
          if (rd_b) p_b <= rdat_b;
          if (pv_a) bus.dout_a <= p_a;
          if (pv_b) bus.dout_b <= p_b;
        end
      end
    end else begin : g_lat1
      // Any READ_LAT other than 2 builds the single-register read path.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bus.dout_a     <= '0;
          bus.dout_b     <= '0;
          bus.dout_vld_a <= 1'b0;
          bus.dout_vld_b <= 1'b0;
        end else begin
          bus.dout_vld_a <= rd_a;
          bus.dout_vld_b <= rd_b;
          if (rd_a) bus.dout_a <= rdat_a;
          if (rd_b) bus.dout_b <= rdat_b;
        end
      end
    end
  endgenerate

  // err_clr drops the old history, but an event in the same cycle still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ww_err   <= 1'b0;
      bus.oob_err  <= 1'b0;
      bus.coll_cnt <= '0;
    end else if (bus.err_clr) begin
      bus.ww_err   <= ww_hit;
      bus.oob_err  <= oob_ev;
      bus.coll_cnt <= coll ? CNT_WIDTH'(1) : '0;
    end else begin
      bus.ww_err  <= bus.ww_err | ww_hit;
      bus.oob_err <= bus.oob_err | oob_ev;
      if (coll && (bus.coll_cnt != '1)) bus.coll_cnt <= bus.coll_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_dp_fwd_bit_en.sv
// Directed bench: identical stimulus into a READ_LAT=1 and a READ_LAT=2 instance;
// read results are scoreboarded by data and arrival cycle, status checked directly.
module tb_sram_dp_fwd_bit_en;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int AS = 1024;
  localparam int CW = 4;
  localparam int OP_I = 0;
  localparam int OP_W = 1;
  localparam int OP_R = 2;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] exp_q0[$], exp_q1[$], exp_q2[$], exp_q3[$];
  int            due_q0[$], due_q1[$], due_q2[$], due_q3[$];

  sram_dp_fwd_bit_en_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus1 ();
  sram_dp_fwd_bit_en_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus2 ();

  sram_dp_fwd_bit_en #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_SPACE(AS), .READ_LAT(1), .CNT_WIDTH(CW))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  sram_dp_fwd_bit_en #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_SPACE(AS), .READ_LAT(2), .CNT_WIDTH(CW))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus2.addr_a   = bus1.addr_a;
  assign bus2.din_a    = bus1.din_a;
  assign bus2.ce_a     = bus1.ce_a;
  assign bus2.wr_en_a  = bus1.wr_en_a;
  assign bus2.bit_en_a = bus1.bit_en_a;
  assign bus2.addr_b   = bus1.addr_b;
  assign bus2.din_b    = bus1.din_b;
  assign bus2.ce_b     = bus1.ce_b;
  assign bus2.wr_en_b  = bus1.wr_en_b;
  assign bus2.bit_en_b = bus1.bit_en_b;
  assign bus2.err_clr  = bus1.err_clr;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  task automatic push(input int k, input logic [DW-1:0] d, input int due);
    case (k)
      0: begin exp_q0.push_back(d); due_q0.push_back(due); end
      1: begin exp_q1.push_back(d); due_q1.push_back(due); end
      2: begin exp_q2.push_back(d); due_q2.push_back(due); end
      default: begin exp_q3.push_back(d); due_q3.push_back(due); end
    endcase
  endtask

  task automatic flush();
    exp_q0.delete(); exp_q1.delete(); exp_q2.delete(); exp_q3.delete();
    due_q0.delete(); due_q1.delete(); due_q2.delete(); due_q3.delete();
  endtask

  function automatic int pending();
    return exp_q0.size() + exp_q1.size() + exp_q2.size() + exp_q3.size();
  endfunction

  task automatic mon(input int k, input logic vld, input logic [DW-1:0] d);
    logic [DW-1:0] ed;
    int            ec;
    bit            have;
    ed = '0;
    ec = 0;
    have = 1'b0;
    if (vld) begin
      case (k)
        0: if (exp_q0.size() > 0) begin ed = exp_q0.pop_front(); ec = due_q0.pop_front(); have = 1'b1; end
        1: if (exp_q1.size() > 0) begin ed = exp_q1.pop_front(); ec = due_q1.pop_front(); have = 1'b1; end
        2: if (exp_q2.size() > 0) begin ed = exp_q2.pop_front(); ec = due_q2.pop_front(); have = 1'b1; end
        default: if (exp_q3.size() > 0) begin ed = exp_q3.pop_front(); ec = due_q3.pop_front(); have = 1'b1; end
      endcase
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL rd_mon%0d: unexpected dout_vld at cycle %0d, dout=%h", k, cyc, d);
      end else if (d !== ed || ec != cyc) begin
        errors++;
        $display("FAIL rd_mon%0d: got %h at cycle %0d, required %h at cycle %0d", k, d, cyc, ed, ec);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, bus1.dout_vld_a, bus1.dout_a);
      mon(1, bus1.dout_vld_b, bus1.dout_b);
      mon(2, bus2.dout_vld_a, bus2.dout_a);
      mon(3, bus2.dout_vld_b, bus2.dout_b);
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string name, input logic ww, input logic oob, input logic [CW-1:0] cnt);
    chk({name, ".ww1"},  16'(bus1.ww_err),   16'(ww));
    chk({name, ".oob1"}, 16'(bus1.oob_err),  16'(oob));
    chk({name, ".cnt1"}, 16'(bus1.coll_cnt), 16'(cnt));
    chk({name, ".ww2"},  16'(bus2.ww_err),   16'(ww));
    chk({name, ".oob2"}, 16'(bus2.oob_err),  16'(oob));
    chk({name, ".cnt2"}, 16'(bus2.coll_cnt), 16'(cnt));
  endtask

  // ---------------- driver ----------------
  task automatic set_idle();
    bus1.ce_a = 1'b1; bus1.wr_en_a = 1'b1; bus1.addr_a = '0; bus1.din_a = '0; bus1.bit_en_a = '1;
    bus1.ce_b = 1'b1; bus1.wr_en_b = 1'b1; bus1.addr_b = '0; bus1.din_b = '0; bus1.bit_en_b = '1;
    bus1.err_clr = 1'b0;
  endtask

  // One cycle of commands on both ports; reads push their expected result.
  task automatic drive(input int op_a, input int ad_a, input int di_a, input int be_a,
                       input int op_b, input int ad_b, input int di_b, input int be_b,
                       input int ex_a, input int ex_b, input bit clr);
    @(posedge clk);
    #1;
    bus1.ce_a     = (op_a == OP_I);
    bus1.wr_en_a  = (op_a != OP_W);
    bus1.addr_a   = AW'(ad_a);
    bus1.din_a    = DW'(di_a);
    bus1.bit_en_a = DW'(be_a);
    bus1.ce_b     = (op_b == OP_I);
    bus1.wr_en_b  = (op_b != OP_W);
    bus1.addr_b   = AW'(ad_b);
    bus1.din_b    = DW'(di_b);
    bus1.bit_en_b = DW'(be_b);
    bus1.err_clr  = clr;
    if (op_a == OP_R) begin push(0, DW'(ex_a), cyc + 1); push(2, DW'(ex_a), cyc + 2); end
    if (op_b == OP_R) begin push(1, DW'(ex_b), cyc + 1); push(3, DW'(ex_b), cyc + 2); end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(OP_I, 0, 0, 'hFF, OP_I, 0, 0, 'hFF, 0, 0, 1'b0);
  endtask

  task automatic wr_a(input int ad, input int di, input int be);
    drive(OP_W, ad, di, be, OP_I, 0, 0, 'hFF, 0, 0, 1'b0);
  endtask

  task automatic rd_a(input int ad, input int ex);
    drive(OP_R, ad, 0, 'hFF, OP_I, 0, 0, 'hFF, ex, 0, 1'b0);
  endtask

  task automatic rd_b(input int ad, input int ex);
    drive(OP_I, 0, 0, 'hFF, OP_R, ad, 0, 'hFF, 0, ex, 1'b0);
  endtask

  task automatic clr_only();
    drive(OP_I, 0, 0, 'hFF, OP_I, 0, 0, 'hFF, 0, 0, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    set_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.dout_a1", 16'(bus1.dout_a), 16'h0);
    chk("rst.vld_a1",  16'(bus1.dout_vld_a), 16'h0);
    chk("rst.dout_b2", 16'(bus2.dout_b), 16'h0);
    chk("rst.vld_b2",  16'(bus2.dout_vld_b), 16'h0);
    chk_flags("rst", 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write then read, then dout holds while idle.
    wr_a(3, 'hA5, 'h00);
    rd_a(3, 'hA5);
    idle(3);
    chk("hold.dout_a1", 16'(bus1.dout_a), 16'hA5);
    chk("hold.vld_a1",  16'(bus1.dout_vld_a), 16'h0);
    chk("hold.dout_a2", 16'(bus2.dout_a), 16'hA5);
    chk("hold.vld_a2",  16'(bus2.dout_vld_a), 16'h0);

    // Disjoint-mask write-write merge on addr 5.
    wr_a(5, 'h00, 'h00);
    drive(OP_W, 5, 'hFF, 'hF0, OP_W, 5, 'hAA, 'h0F, 0, 0, 1'b0);
    idle(1);
    chk_flags("ww_disjoint", 1'b0, 1'b0, 4'h1);
    rd_b(5, 'hAF);

    // Overlapping write-write on addr 6: A wins.
    drive(OP_W, 6, 'h11, 'h00, OP_W, 6, 'h22, 'h00, 0, 0, 1'b0);
    idle(1);
    chk_flags("ww_overlap", 1'b1, 1'b0, 4'h2);
    rd_a(6, 'h11);

    // Forwarding A->B on addr 7 and B->A on addr 8.
    wr_a(7, 'h3C, 'h00);
    drive(OP_W, 7, 'hC3, 'h0F, OP_R, 7, 0, 'hFF, 0, 'hCC, 1'b0);
    rd_a(7, 'hCC);
    wr_a(8, 'h00, 'h00);
    drive(OP_R, 8, 0, 'hFF, OP_W, 8, 'h5A, 'hF0, 'h0A, 0, 1'b0);
    rd_b(8, 'h0A);

    // Back-to-back reads on both ports; same-address read/read is not a conflict.
    drive(OP_R, 3, 0, 'hFF, OP_R, 3, 0, 'hFF, 'hA5, 'hA5, 1'b0);
    drive(OP_R, 5, 0, 'hFF, OP_R, 8, 0, 'hFF, 'hAF, 'h0A, 1'b0);
    drive(OP_R, 6, 0, 'hFF, OP_R, 7, 0, 'hFF, 'h11, 'hCC, 1'b0);
    drive(OP_R, 7, 0, 'hFF, OP_R, 5, 0, 'hFF, 'hCC, 'hAF, 1'b0);
    idle(1);
    chk_flags("b2b", 1'b1, 1'b0, 4'h4);

    // err_clr alone, then err_clr racing an overlap event.
    clr_only();
    idle(1);
    chk_flags("clr", 1'b0, 1'b0, 4'h0);
    drive(OP_W, 6, 'h11, 'h00, OP_W, 6, 'h22, 'h00, 0, 0, 1'b1);
    idle(1);
    chk_flags("clr_vs_set", 1'b1, 1'b0, 4'h1);
    clr_only();

    // Out-of-range accesses.
    wr_a(0, 'h77, 'h00);
    rd_a(1024, 'h00);
    idle(1);
    chk_flags("oob_rd", 1'b0, 1'b1, 4'h0);
    clr_only();
    idle(1);
    chk_flags("oob_clr", 1'b0, 1'b0, 4'h0);
    drive(OP_I, 0, 0, 'hFF, OP_W, 1024, 'hFF, 'h00, 0, 0, 1'b0);
    rd_a(0, 'h77);
    drive(OP_W, 1024, 'h55, 'h00, OP_R, 1024, 0, 'hFF, 0, 'h00, 1'b0);
    idle(1);
    chk_flags("oob_wr", 1'b0, 1'b1, 4'h0);
    clr_only();

    // Counter saturation at 0xF over 19 conflict cycles.
    for (int i = 0; i < 14; i++) drive(OP_W, 9, 'h40, 'h00, OP_W, 9, 'h04, 'hFF, 0, 0, 1'b0);
    idle(1);
    chk_flags("cnt14", 1'b0, 1'b0, 4'hE);
    for (int i = 0; i < 5; i++) drive(OP_W, 9, 'h40, 'h00, OP_W, 9, 'h04, 'hFF, 0, 0, 1'b0);
    idle(1);
    chk_flags("cnt_sat", 1'b0, 1'b0, 4'hF);
    rd_a(9, 'h40);
    idle(3);

    // Asynchronous reset with reads in flight; memory must survive.
    drive(OP_R, 3, 0, 'hFF, OP_R, 5, 0, 'hFF, 'hA5, 'hAF, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    set_idle();
    flush();
    #1;
    chk("arst.dout_a1", 16'(bus1.dout_a), 16'h0);
    chk("arst.vld_a1",  16'(bus1.dout_vld_a), 16'h0);
    chk("arst.dout_b1", 16'(bus1.dout_b), 16'h0);
    chk("arst.dout_a2", 16'(bus2.dout_a), 16'h0);
    chk("arst.vld_b2",  16'(bus2.dout_vld_b), 16'h0);
    chk_flags("arst", 1'b0, 1'b0, 4'h0);
    @(posedge clk);
    #1;
    chk("arst_hold.vld_a2", 16'(bus2.dout_vld_a), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(OP_R, 9, 0, 'hFF, OP_R, 3, 0, 'hFF, 'h40, 'hA5, 1'b0);
    idle(1);

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && pending() != 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    chk("drain.q_pending", 16'(pending()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
